// File: rtl/mul16_pkg.sv
// Shared constants for the sequential 16x16 shift-add multiplier.
package mul16_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] ITER_LAST = 4'd15;

endpackage

// File: rtl/mul16_seq_add16.sv
// Add16: 16-bit adder, carry-out dropped (sum is modulo 2^16).
module Add16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] out
);

    assign out = a + b;

endmodule

// File: rtl/mul16_seq.sv
// Sequential shift-add multiplier, low 16 bits of a*b via one shared Add16.
// Optional build macro MUL16_EARLY_EXIT_EN: finish once the remaining multiplier bits are all zero.
//
// state   | meaning
// IDLE    | waiting for start
// RUN     | one shift-add iteration per cycle
// DONE    | out just updated, done pulse; start accepted here too
module mul16_seq
    import mul16_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    logic [1:0]       state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [3:0]       count;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] mplier_shift;
    logic             last_iter;

    Add16 u_add16 (
        .a   (acc),
        .b   (mcand),
        .out (sum)
    );

    assign acc_next     = mplier[0] ? sum : acc;
    assign mplier_shift = mplier >> 1;

`ifdef MUL16_EARLY_EXIT_EN
    assign last_iter = (count == ITER_LAST) || (mplier_shift == '0);
`else
    assign last_iter = (count == ITER_LAST);
`endif

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            out    <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        mcand  <= a;
                        mplier <= b;
                        acc    <= '0;
                        count  <= '0;
                        state  <= ST_RUN;
                    end else begin
                        state  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier_shift;
                    count  <= count + 4'd1;
                    // out is written only here, so it holds between completions
                    if (last_iter) begin
                        state <= ST_DONE;
                        out   <= acc_next;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul16_seq.sv
// Directed self-checking bench for mul16_seq (default and MUL16_EARLY_EXIT_EN builds).
module tb_mul16_seq;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] out_w;

    int total = 0;
    int bad   = 0;

    mul16_seq #(.WIDTH(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .out     (out_w)
    );

    always #5 clock = ~clock;

`ifdef MUL16_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    // edges from capture to done for a given multiplier, written out by hand
    function automatic int exp_lat(input int early_val);
        return EARLY ? early_val : 16;
    endfunction

    // drive start at a negedge; returns at the negedge after the capture edge
    task automatic launch(input logic [15:0] av, input logic [15:0] bv);
        @(negedge clock);
        a = av; b = bv; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
    endtask

    // from the negedge after capture, count edges until done (0 on timeout)
    task automatic wait_done(output int lat, output int busy_cycles);
        lat = 0;
        busy_cycles = busy ? 1 : 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busy_cycles++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clock);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
        total++; if (out_w !== 16'h0000) begin bad++; $display("FAIL reset_out got=%h want=0000", out_w); end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_basic();
        int lat, bc, out_moved;
        lat = 0; bc = 0; out_moved = 0;
        launch(16'h0003, 16'h0005);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_after_e0 got=%0b want=1", busy); end
        bc = 1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (done) begin lat = k; break; end
            if (busy) bc++;
            if (out_w !== 16'h0000) out_moved++;
        end
        total++; if (lat != exp_lat(3)) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", lat, exp_lat(3)); end
        total++; if (bc != exp_lat(3)) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=%0d", bc, exp_lat(3)); end
        total++; if (out_moved != 0) begin bad++; $display("FAIL basic_out_hold got=%0d changes want=0", out_moved); end
        total++; if (out_w !== 16'h000F) begin bad++; $display("FAIL basic_out got=%h want=000F", out_w); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got=%0b want=0", busy); end
        @(negedge clock);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%0b want=0", done); end
        total++; if (out_w !== 16'h000F) begin bad++; $display("FAIL basic_out_held got=%h want=000F", out_w); end
    endtask

    task automatic test_wrap();
        int lat, bc;
        launch(16'hFFFF, 16'hFFFF);
        wait_done(lat, bc);
        total++; if (lat != 16) begin bad++; $display("FAIL wrap_ffff_latency got=%0d want=16", lat); end
        total++; if (out_w !== 16'h0001) begin bad++; $display("FAIL wrap_ffff_out got=%h want=0001", out_w); end
        launch(16'h1234, 16'h0010);
        wait_done(lat, bc);
        total++; if (lat != exp_lat(5)) begin bad++; $display("FAIL wrap_shift_latency got=%0d want=%0d", lat, exp_lat(5)); end
        total++; if (out_w !== 16'h2340) begin bad++; $display("FAIL wrap_shift_out got=%h want=2340", out_w); end
        launch(16'h0003, 16'h8000);
        wait_done(lat, bc);
        total++; if (lat != 16) begin bad++; $display("FAIL msb_mplier_latency got=%0d want=16", lat); end
        total++; if (out_w !== 16'h8000) begin bad++; $display("FAIL msb_mplier_out got=%h want=8000", out_w); end
    endtask

    task automatic test_zero();
        int lat, bc;
        launch(16'hAAAA, 16'h0000);
        wait_done(lat, bc);
        total++; if (lat != exp_lat(1)) begin bad++; $display("FAIL zero_latency got=%0d want=%0d", lat, exp_lat(1)); end
        total++; if (out_w !== 16'h0000) begin bad++; $display("FAIL zero_out got=%h want=0000", out_w); end
        @(negedge clock);
    endtask

    task automatic test_start_while_busy();
        int dly, ndone;
        dly = EARLY ? 2 : 5;
        ndone = 0;
        launch(16'h0007, 16'h0006);
        for (int k = 1; k <= 30; k++) begin
            if (k == dly) begin a = 16'h0002; b = 16'h0002; start = 1'b1; end
            else start = 1'b0;
            @(posedge clock);
            @(negedge clock);
            if (done) begin
                ndone++;
                total++; if (out_w !== 16'h002A) begin bad++; $display("FAIL busy_start_out got=%h want=002A", out_w); end
            end
        end
        start = 1'b0;
        total++; if (ndone != 1) begin bad++; $display("FAIL busy_start_done_count got=%0d want=1", ndone); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_start_idle got=%0b want=0", busy); end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, bc;
        launch(16'h0011, 16'h0003);
        wait_done(lat1, bc);
        total++; if (out_w !== 16'h0033) begin bad++; $display("FAIL b2b_first_out got=%h want=0033", out_w); end
        a = 16'h0100; b = 16'h0100; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept_in_done got=%0b want=1", busy); end
        wait_done(lat2, bc);
        total++; if (lat2 + 1 != exp_lat(9) + 1) begin bad++; $display("FAIL b2b_spacing got=%0d want=%0d", lat2 + 1, exp_lat(9) + 1); end
        total++; if (out_w !== 16'h0000) begin bad++; $display("FAIL b2b_second_out got=%h want=0000", out_w); end
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        int lat, bc, ndone;
        ndone = 0;
        launch(16'h0009, 16'h0009);
        repeat ((EARLY ? 2 : 8) - 1) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%0b want=0", busy); end
        total++; if (out_w !== 16'h0000) begin bad++; $display("FAIL midreset_out got=%h want=0000", out_w); end
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (done) ndone++;
        end
        total++; if (ndone != 0) begin bad++; $display("FAIL midreset_no_done got=%0d want=0", ndone); end
        launch(16'h0009, 16'h0009);
        wait_done(lat, bc);
        total++; if (lat != exp_lat(4)) begin bad++; $display("FAIL midreset_rerun_latency got=%0d want=%0d", lat, exp_lat(4)); end
        total++; if (out_w !== 16'h0051) begin bad++; $display("FAIL midreset_rerun_out got=%h want=0051", out_w); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_zero();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
